// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two packet requesters, the arbiter and the UART
// transmitter input port.
interface uart_tx_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] grant;
  logic       trunc;

  modport slave (
    input  req0_data, req0_last, req0_valid,
    output req0_ready,
    input  req1_data, req1_last, req1_valid,
    output req1_ready,
    output tx_data, tx_valid,
    input  tx_ready,
    output grant, trunc
  );

  modport master (
    output req0_data, req0_last, req0_valid,
    input  req0_ready,
    output req1_data, req1_last, req1_valid,
    input  req1_ready,
    input  tx_data, tx_valid,
    output tx_ready,
    input  grant, trunc
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level two-way arbiter in front of a UART transmitter: the owner keeps
// the transmitter until its last byte or until PKT_MAX bytes force a release.
module uart_tx_arbiter #(
  parameter int unsigned PKT_MAX = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(PKT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t           state_r;
  logic [1:0]       grant_r;
  logic             prev_owner_r;
  logic [CNT_W-1:0] count_r;
  logic             trunc_r;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r;

  logic             ready0_s;
  logic             ready1_s;
  logic             accept_s;
  logic             acc_last_s;
  logic [7:0]       acc_data_s;
  logic             at_max_s;

  // Owner's ready depends only on state and output-register occupancy, never on valid.
  always_comb begin
    ready0_s   = 1'b0;
    ready1_s   = 1'b0;
    accept_s   = 1'b0;
    acc_last_s = 1'b0;
    acc_data_s = 8'h00;
    case (state_r)
      OWN0: begin
        ready0_s   = !tx_valid_r || bus.tx_ready;
        accept_s   = bus.req0_valid && ready0_s;
        acc_last_s = bus.req0_last;
        acc_data_s = bus.req0_data;
      end
      OWN1: begin
        ready1_s   = !tx_valid_r || bus.tx_ready;
        accept_s   = bus.req1_valid && ready1_s;
        acc_last_s = bus.req1_last;
        acc_data_s = bus.req1_data;
      end
      default: begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
      end
    endcase
    at_max_s = (count_r + CNT_W'(1)) == CNT_W'(PKT_MAX);
  end

  // Ownership FSM with byte counter, round-robin memory and truncation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= 2'b00;
      prev_owner_r <= 1'b1;
      count_r      <= {CNT_W{1'b0}};
      trunc_r      <= 1'b0;
    end else begin
      trunc_r <= 1'b0;
      case (state_r)
        IDLE: begin
          count_r <= {CNT_W{1'b0}};
          // On a tie the requester that did not own last time wins.
          if (bus.req0_valid && (!bus.req1_valid || prev_owner_r)) begin
            state_r <= OWN0;
            grant_r <= 2'b01;
          end else if (bus.req1_valid) begin
            state_r <= OWN1;
            grant_r <= 2'b10;
          end else begin
            state_r <= IDLE;
            grant_r <= 2'b00;
          end
        end
        OWN0, OWN1: begin
          if (accept_s && (acc_last_s || at_max_s)) begin
            state_r      <= IDLE;
            grant_r      <= 2'b00;
            prev_owner_r <= (state_r == OWN1);
            count_r      <= {CNT_W{1'b0}};
            trunc_r      <= !acc_last_s;
          end else if (accept_s) begin
            count_r <= count_r + CNT_W'(1);
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 2'b00;
          count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Single-entry output register: load wins over drain so a full cycle is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else if (accept_s) begin
      tx_data_r  <= acc_data_s;
      tx_valid_r <= 1'b1;
    end else if (bus.tx_ready) begin
      tx_data_r  <= tx_data_r;
      tx_valid_r <= 1'b0;
    end else begin
      tx_data_r  <= tx_data_r;
      tx_valid_r <= tx_valid_r;
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.tx_data    = tx_data_r;
  assign bus.tx_valid   = tx_valid_r;
  assign bus.grant      = grant_r;
  assign bus.trunc      = trunc_r;

endmodule
